// File: rtl/writeback_stage.sv
// writeback_stage: RV32I WB stage; load wait/align, writeback select, error pulses, instret
module writeback_stage #(
  parameter int CNT_WIDTH    = 64,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 valid_in,
  output logic                 in_ready,
  input  logic [31:0]          pc_in,
  input  logic [31:0]          alu_result_in,
  input  logic [4:0]           rd_in,
  input  logic                 reg_write_in,
  input  logic                 mem_to_reg_in,
  input  logic                 jump_in,
  input  logic [2:0]           funct3_in,
  input  logic                 dmem_rvalid,
  input  logic [31:0]          dmem_rdata,
  output logic                 wb_enable,
  output logic [4:0]           wb_rd,
  output logic [31:0]          wb_data,
  output logic                 misalign_err,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] instret
);
  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  state_t state, state_d;
  logic [7:0] cnt;
  logic [4:0] rd_q;
  logic we_q;
  logic [2:0] f3_q;
  logic [1:0] a_q;
  logic idle, accept, mis_in, ld_go, load_done, nl_done, retire, wb_en_d, mis_d, timeout;
  logic [31:0] data_d;

  function automatic logic [31:0] align(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f3);
    logic [7:0] b;
    logic [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    return f3[1] ? w : f3[0] ? {{16{h[15] & ~f3[2]}}, h} : {{24{b[7] & ~f3[2]}}, b};
  endfunction

  assign in_ready = idle;

  always_comb begin
    idle      = state == IDLE;
    accept    = idle && valid_in && !flush;
    mis_in    = funct3_in[1] ? |alu_result_in[1:0] : funct3_in[0] & alu_result_in[0];
    ld_go     = accept && mem_to_reg_in && !mis_in;
    mis_d     = accept && mem_to_reg_in && mis_in;
    load_done = dmem_rvalid && (ld_go || !idle);
    nl_done   = accept && !mem_to_reg_in;
    retire    = load_done || nl_done;
    wb_en_d   = retire && (idle ? reg_write_in && |rd_in : we_q);
    timeout   = !idle && !dmem_rvalid && cnt == 8'(LOAD_TIMEOUT - 1);
    state_d   = idle ? (ld_go && !dmem_rvalid ? WAIT_LOAD : IDLE)
                     : (dmem_rvalid || timeout ? IDLE : WAIT_LOAD);
    data_d    = nl_done ? (jump_in ? pc_in + 32'd4 : alu_result_in)
                        : align(dmem_rdata, idle ? alu_result_in[1:0] : a_q, idle ? funct3_in : f3_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      wb_enable    <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      instret      <= '0;
      rd_q         <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      a_q          <= '0;
    end else begin
      state        <= state_d;
      cnt          <= idle ? '0 : cnt + 8'(!dmem_rvalid);
      wb_enable    <= wb_en_d;
      misalign_err <= mis_d;
      timeout_err  <= timeout;
      instret      <= instret + CNT_WIDTH'(retire);
      if (wb_en_d) begin
        wb_rd   <= idle ? rd_in : rd_q;
        wb_data <= data_d;
      end
      if (accept) begin
        rd_q <= rd_in;
        we_q <= reg_write_in && |rd_in;
        f3_q <= funct3_in;
        a_q  <= alu_result_in[1:0];
      end
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed table vectors plus multi-cycle load, timeout and reset sequences
module tb_writeback_stage;
  logic clk = 0, rst = 1, flush = 0, valid_in = 0, in_ready;
  logic [31:0] pc_in = 0, alu_result_in = 0, dmem_rdata = 0, wb_data;
  logic [4:0] rd_in = 0, wb_rd;
  logic reg_write_in = 0, mem_to_reg_in = 0, jump_in = 0, dmem_rvalid = 0;
  logic [2:0] funct3_in = 0;
  logic wb_enable, misalign_err, timeout_err;
  logic [63:0] instret;
  int n_cmp = 0, n_err = 0;

  writeback_stage #(.CNT_WIDTH(64), .LOAD_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .in_ready(in_ready),
    .pc_in(pc_in), .alu_result_in(alu_result_in), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in), .jump_in(jump_in), .funct3_in(funct3_in),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_enable(wb_enable), .wb_rd(wb_rd),
    .wb_data(wb_data), .misalign_err(misalign_err), .timeout_err(timeout_err), .instret(instret));

  always #5 clk = ~clk;

  typedef struct {
    logic v, fl;
    logic [31:0] pc, alu;
    logic [4:0] rd;
    logic rw, m2r, jmp;
    logic [2:0] f3;
    logic rv;
    logic [31:0] rdata;
    logic e_en;
    logic [4:0] e_rd;
    logic [31:0] e_data;
    logic e_mis;
    logic [63:0] e_inst;
  } vec_t;
  vec_t vec [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] rd,
                       input logic rw, input logic m2r, input logic jmp, input logic [2:0] f3);
    valid_in = 1; pc_in = pc; alu_result_in = alu; rd_in = rd;
    reg_write_in = rw; mem_to_reg_in = m2r; jump_in = jmp; funct3_in = f3;
  endtask

  task automatic load_wait(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp, input logic [63:0] inst);
    drive(32'h0, addr, 5'd12, 1, 1, 0, f3);
    dmem_rvalid = 0;
    step();
    valid_in = 0;
    flush = 1;
    chk({name, " wait in_ready"}, in_ready, 0);
    step();
    chk({name, " wait2 in_ready"}, in_ready, 0);
    chk({name, " wait2 wb_enable"}, wb_enable, 0);
    flush = 0;
    dmem_rvalid = 1; dmem_rdata = rdata;
    step();
    dmem_rvalid = 0;
    chk({name, " wb_enable"}, wb_enable, 1);
    chk({name, " wb_rd"}, wb_rd, 12);
    chk({name, " wb_data"}, wb_data, exp);
    chk({name, " instret"}, instret, inst);
    chk({name, " in_ready"}, in_ready, 1);
  endtask

  initial begin
    vec[0]  = '{1,0,32'h0,32'h5,3,1,0,0,3'b000,0,32'h0, 1,3,32'h5,0,1};
    vec[1]  = '{1,0,32'h100,32'h200,1,1,0,1,3'b000,0,32'h0, 1,1,32'h104,0,2};
    vec[2]  = '{1,0,32'h0,32'h1000,5,1,1,0,3'b010,1,32'hDEADBEEF, 1,5,32'hDEADBEEF,0,3};
    vec[3]  = '{1,0,32'h0,32'h1001,6,1,1,0,3'b000,1,32'h00007F00, 1,6,32'h7F,0,4};
    vec[4]  = '{1,0,32'h0,32'h1002,7,1,1,0,3'b001,1,32'h80FF0000, 1,7,32'hFFFF80FF,0,5};
    vec[5]  = '{1,0,32'h0,32'h1001,8,1,1,0,3'b010,1,32'h11111111, 0,7,32'hFFFF80FF,1,5};
    vec[6]  = '{1,0,32'h0,32'h1003,8,1,1,0,3'b101,0,32'h0, 0,7,32'hFFFF80FF,1,5};
    vec[7]  = '{1,1,32'h0,32'h9,9,1,0,0,3'b000,0,32'h0, 0,7,32'hFFFF80FF,0,5};
    vec[8]  = '{1,0,32'h0,32'h77,0,1,0,0,3'b000,0,32'h0, 0,7,32'hFFFF80FF,0,6};
    vec[9]  = '{1,0,32'h0,32'h55,4,0,0,0,3'b000,0,32'h0, 0,7,32'hFFFF80FF,0,7};
    vec[10] = '{0,0,32'h0,32'h0,4,1,1,0,3'b000,1,32'hABCD0000, 0,7,32'hFFFF80FF,0,7};
    vec[11] = '{1,0,32'h0,32'hFFFFFFFF,2,1,0,0,3'b000,0,32'h0, 1,2,32'hFFFFFFFF,0,8};
    vec[12] = '{1,0,32'h0,32'h2,10,1,1,0,3'b100,1,32'h00800000, 1,10,32'h80,0,9};
    vec[13] = '{1,0,32'h0,32'h0,11,1,1,0,3'b011,1,32'h12345678, 1,11,32'h12345678,0,10};
    step();
    step();
    rst = 0;
    chk("reset wb_enable", wb_enable, 0);
    chk("reset wb_data", wb_data, 0);
    chk("reset instret", instret, 0);
    chk("reset in_ready", in_ready, 1);
    for (int i = 0; i < 14; i++) begin
      drive(vec[i].pc, vec[i].alu, vec[i].rd, vec[i].rw, vec[i].m2r, vec[i].jmp, vec[i].f3);
      valid_in = vec[i].v; flush = vec[i].fl;
      dmem_rvalid = vec[i].rv; dmem_rdata = vec[i].rdata;
      step();
      valid_in = 0; flush = 0; dmem_rvalid = 0;
      chk($sformatf("vec%0d wb_enable", i), wb_enable, vec[i].e_en);
      chk($sformatf("vec%0d wb_rd", i), wb_rd, vec[i].e_rd);
      chk($sformatf("vec%0d wb_data", i), wb_data, vec[i].e_data);
      chk($sformatf("vec%0d misalign_err", i), misalign_err, vec[i].e_mis);
      chk($sformatf("vec%0d instret", i), instret, vec[i].e_inst);
      chk($sformatf("vec%0d in_ready", i), in_ready, 1);
    end
    step();
    chk("misalign pulse gone", misalign_err, 0);
    load_wait("LB", 3'b000, 32'h1003, 32'h80FF0000, 32'hFFFFFF80, 11);
    load_wait("LBU", 3'b100, 32'h1003, 32'h80FF0000, 32'h00000080, 12);
    load_wait("LHU", 3'b101, 32'h1002, 32'h80FF0000, 32'h000080FF, 13);
    step();
    chk("wb_enable one cycle", wb_enable, 0);
    drive(32'h0, 32'h2000, 5'd13, 1, 1, 0, 3'b010);
    step();
    valid_in = 0;
    repeat (3) step();
    chk("timeout early err", timeout_err, 0);
    chk("timeout early in_ready", in_ready, 0);
    step();
    chk("timeout_err", timeout_err, 1);
    chk("timeout wb_enable", wb_enable, 0);
    chk("timeout instret", instret, 13);
    chk("timeout in_ready", in_ready, 1);
    step();
    chk("timeout pulse gone", timeout_err, 0);
    drive(32'h0, 32'h3000, 5'd14, 1, 1, 0, 3'b010);
    step();
    valid_in = 0;
    chk("pre-rst in_ready", in_ready, 0);
    rst = 1;
    dmem_rvalid = 1;
    step();
    rst = 0;
    dmem_rvalid = 0;
    chk("rst in wait in_ready", in_ready, 1);
    chk("rst in wait instret", instret, 0);
    chk("rst in wait wb_enable", wb_enable, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
